mix_mem_arbiter: RTL and testbench
==================================

MIX_MEM_ARBITER -- requirements
Module: mix_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4: consecutive cycles io may wait before it overrides CPU priority.
REQ-002 Parameter MAX_BURST, 8: maximum consecutive locked io grants.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  CPU access request; held until granted.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  12  word address 0..4095.
REQ-008 cpu_wdata  in  31  sign plus five 6-bit bytes.
REQ-009 cpu_gnt  out  1  combinational; CPU access issued this cycle.
REQ-010 cpu_rvalid  out  1  registered; rdata holds CPU read result.
REQ-011 io_req, io_we, io_addr[11:0], io_wdata[30:0]  in  I/O (loader/tape) port, same meaning as CPU.
REQ-012 io_lock  in  1  io requests that the grant be retained next cycle (burst).
REQ-013 io_gnt  out  1  combinational; io access issued this cycle.
REQ-014 io_rvalid  out  1  registered; rdata holds io read result.
REQ-015 rdata  out  31  read data, valid only with cpu_rvalid or io_rvalid.
REQ-016 mem_en, mem_we  out  1  memory port strobes; mem_addr out 12; mem_wdata out 31; mem_rdata in 31, synchronous read, 1-cycle latency.

Function
REQ-017 At most one of cpu_gnt/io_gnt shall be high per cycle; mem_en = cpu_gnt|io_gnt; mem_we/addr/wdata are muxed from the granted port; mem_we = 0 when no grant.
REQ-018 Default priority: CPU wins when both request.
REQ-019 wait_cnt shall increment (saturating at STARVE_LIMIT) each cycle io_req=1 and io_gnt=0, and clear on io_gnt or io_req=0.
REQ-020 When wait_cnt == STARVE_LIMIT and io_req=1, io shall be granted regardless of cpu_req.
REQ-021 Burst: after an io grant with io_lock=1, io keeps priority the next cycle while io_req=1; burst_cnt counts consecutive io grants.
REQ-022 When burst_cnt == MAX_BURST and cpu_req=1, the CPU shall receive exactly one grant before io may be granted again; burst_cnt clears on any non-io cycle.
REQ-023 Grant decision shall be combinational from current requests and registered state; no idle cycle between back-to-back grants.
REQ-024 Read latency: a read granted in cycle N asserts the matching rvalid in N+1, with rdata = mem_rdata; writes produce no rvalid.
REQ-025 An owner register routes rvalid; never both rvalid high.
REQ-026 Write in cycle N followed by read of the same address in N+1 (either port) shall return the written value.
REQ-027 Requests with req=0 are ignored; we/addr/wdata are don't-care then.

Reset
REQ-028 While reset=1: cpu_gnt, io_gnt, mem_en, mem_we, cpu_rvalid, io_rvalid = 0; wait_cnt, burst_cnt, owner cleared.
REQ-029 Reset asserted the cycle after a read grant shall suppress that read's rvalid.
REQ-030 First cycle after reset deasserts, arbitration proceeds normally (CPU priority).

Verification
REQ-031 Only cpu_req read addr 0x005 (mem=0x12345678) -> cpu_gnt same cycle, cpu_rvalid next cycle, rdata=0x12345678.
REQ-032 cpu_req and io_req held continuously, no lock -> cpu_gnt 4 cycles, io_gnt cycle 5, pattern repeats; never simultaneous grants.
REQ-033 io burst, io_lock=1, cpu_req=1 throughout, 10 io writes -> 8 consecutive io_gnt, 1 cpu_gnt, then remaining io grants.
REQ-034 io write 0x7FFFFFFF to 0xFFF cycle N, CPU read 0xFFF cycle N+1 -> cpu_rvalid N+2 with rdata=0x7FFFFFFF.
REQ-035 CPU read granted, reset high next cycle -> cpu_rvalid stays 0; all grants 0 during reset; wait_cnt 0 after.
REQ-036 Alternating cpu/io reads every cycle -> rvalid toggles between ports each cycle with correct data per address.

Source files
------------

// File: rtl/mix_mem_arbiter_if.sv
// Bus bundle between the CPU/IO requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mix_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [30:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;

  logic        io_req;
  logic        io_we;
  logic [11:0] io_addr;
  logic [30:0] io_wdata;
  logic        io_lock;
  logic        io_gnt;
  logic        io_rvalid;

  logic [30:0] rdata;

  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [30:0] mem_wdata;
  logic [30:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_addr, io_wdata, io_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_addr, io_wdata, io_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mix_mem_arbiter.sv
// Two-port (CPU / IO) arbiter onto one synchronous-read memory: CPU priority,
// IO starvation override, locked IO bursts capped so the CPU gets a slot.
module mix_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic               clk,
  input  logic               reset,
  mix_mem_arbiter_if.slave   bus
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          lock_q, lock_d;
  logic          rd_cpu_q, rd_cpu_d;
  logic          rd_io_q, rd_io_d;

  logic starving;
  logic burst_full;
  logic cpu_yield;
  logic io_prio;
  logic cpu_gnt_c;
  logic io_gnt_c;

  // Grant decision: purely combinational from requests and registered counters.
  always_comb begin
    starving   = bus.io_req && (wait_cnt_q == WW'(STARVE_LIMIT));
    burst_full = (burst_cnt_q == BW'(MAX_BURST));
    cpu_yield  = burst_full && bus.cpu_req;
    io_prio    = bus.io_req && (starving || (lock_q && !cpu_yield));
    cpu_gnt_c  = !reset && bus.cpu_req && !io_prio;
    io_gnt_c   = !reset && bus.io_req && !cpu_gnt_c;
  end

  always_comb begin
    bus.cpu_gnt   = cpu_gnt_c;
    bus.io_gnt    = io_gnt_c;
    bus.mem_en    = cpu_gnt_c || io_gnt_c;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (cpu_gnt_c) begin
      bus.mem_we = bus.cpu_we;
    end else if (io_gnt_c) begin
      bus.mem_we    = bus.io_we;
      bus.mem_addr  = bus.io_addr;
      bus.mem_wdata = bus.io_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (bus.io_req && !io_gnt_c) begin
      wait_cnt_d = starving ? wait_cnt_q : wait_cnt_q + WW'(1);
    end

    burst_cnt_d = '0;
    if (io_gnt_c) begin
      burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + BW'(1);
    end

    // The burst lock survives the single forced CPU slot so the burst resumes.
    lock_d = 1'b0;
    if (io_gnt_c) begin
      lock_d = bus.io_lock;
    end else if (cpu_gnt_c && burst_full) begin
      lock_d = lock_q && bus.io_req;
    end

    rd_cpu_d = cpu_gnt_c && !bus.cpu_we;
    rd_io_d  = io_gnt_c && !bus.io_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      lock_q      <= 1'b0;
      rd_cpu_q    <= 1'b0;
      rd_io_q     <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      lock_q      <= lock_d;
      rd_cpu_q    <= rd_cpu_d;
      rd_io_q     <= rd_io_d;
    end
  end

  // Gating with reset kills a read whose data would land during reset.
  always_comb begin
    bus.cpu_rvalid = rd_cpu_q && !reset;
    bus.io_rvalid  = rd_io_q && !reset;
    bus.rdata      = bus.mem_rdata;
  end
endmodule

// File: tb/tb_mix_mem_arbiter.sv
// Randomized + directed bench for mix_mem_arbiter with a history-based reference
// model of the arbitration rules and a shadow memory for read data.
module tb_mix_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 8;

  typedef struct packed {
    bit ireq;
    bit ignt;
    bit cgnt;
    bit lock;
    bit forced;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mix_mem_arbiter_if bus();

  mix_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory device on the bus: synchronous read, one cycle latency.
  logic [30:0] tb_mem [0:4095] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  logic [30:0] ref_mem [0:4095] = '{default: '0};
  rec_t        hist[$];
  bit          pend_valid = 0;
  bit          pend_io = 0;
  logic [30:0] pend_data = '0;

  bit          last_cg, last_ig;
  bit          obs_cg, obs_ig, obs_crv, obs_irv;
  logic [30:0] obs_rdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [11:0] addr, input logic [30:0] data);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data;
  endtask

  task automatic set_io(input bit req, input bit we, input logic [11:0] addr, input logic [30:0] data,
                        input bit lock);
    bus.io_req = req; bus.io_we = we; bus.io_addr = addr; bus.io_wdata = data; bus.io_lock = lock;
  endtask

  // One clock cycle: predict from the rules, compare at negedge, advance the model.
  task automatic step();
    bit cg, ig, starving, at_cap, locked, exp_we;
    int n, run;
    rec_t r;
    logic [11:0] a;
    logic [30:0] wd;
    @(negedge clk);
    n = hist.size();
    starving = (n >= STARVE_LIMIT);
    for (int k = 0; k < STARVE_LIMIT && k < n; k++)
      if (!(hist[n-1-k].ireq && !hist[n-1-k].ignt)) starving = 0;
    run = 0;
    for (int k = n - 1; k >= 0; k--) begin
      if (!hist[k].ignt) break;
      run++;
    end
    at_cap = (run >= MAX_BURST);
    locked = (n >= 1 && hist[n-1].ignt && hist[n-1].lock) ||
             (n >= 2 && hist[n-1].forced && hist[n-1].ireq && hist[n-2].ignt && hist[n-2].lock);
    cg = 0; ig = 0;
    if (!reset) begin
      if (bus.io_req && (starving || (locked && !(at_cap && bus.cpu_req)))) ig = 1;
      else if (bus.cpu_req) cg = 1;
      else if (bus.io_req) ig = 1;
    end
    exp_we = cg ? bus.cpu_we : (ig ? bus.io_we : 1'b0);
    a  = cg ? bus.cpu_addr : bus.io_addr;
    wd = cg ? bus.cpu_wdata : bus.io_wdata;

    check_val("cpu_gnt", 32'(bus.cpu_gnt), 32'(cg));
    check_val("io_gnt", 32'(bus.io_gnt), 32'(ig));
    check_val("mem_en", 32'(bus.mem_en), 32'(cg | ig));
    check_val("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (cg || ig) check_val("mem_addr", 32'(bus.mem_addr), 32'(a));
    if ((cg || ig) && exp_we) check_val("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
    check_val("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!reset && pend_valid && !pend_io));
    check_val("io_rvalid", 32'(bus.io_rvalid), 32'(!reset && pend_valid && pend_io));
    if (!reset && pend_valid) check_val("rdata", 32'(bus.rdata), 32'(pend_data));

    obs_cg = bus.cpu_gnt; obs_ig = bus.io_gnt;
    obs_crv = bus.cpu_rvalid; obs_irv = bus.io_rvalid; obs_rdata = bus.rdata;
    last_cg = cg; last_ig = ig;

    if (reset) begin
      hist.delete();
      pend_valid = 0;
    end else begin
      pend_valid = (cg || ig) && !exp_we;
      pend_io = ig;
      pend_data = ref_mem[a];
      if ((cg || ig) && exp_we) ref_mem[a] = wd;
      if (cg || ig)
        $display("txn t=%0t port=%s op=%s addr=0x%03h data=0x%08h", $time, cg ? "cpu" : "io",
                 exp_we ? "wr" : "rd", a, exp_we ? wd : pend_data);
      r.ireq = bus.io_req; r.ignt = ig; r.cgnt = cg; r.lock = bus.io_lock; r.forced = cg && at_cap;
      hist.push_back(r);
      if (hist.size() > 32) void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_cpu(0, 0, '0, '0);
    set_io(0, 0, '0, '0, 0);
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    int io_done, first_run, cpu_mid;
    bit seen_io, run_open;
    set_cpu(1, 0, 12'h001, '0);
    set_io(1, 0, 12'h002, '0, 1);
    bus.mem_rdata = '0;
    #1;
    // Reset with both ports requesting: nothing may be granted.
    step();
    step();
    reset = 0;
    step();
    check_val("first_after_reset_cpu", 32'(obs_cg), 32'd1);

    // Single CPU read of a known word, write-then-read on consecutive cycles.
    do_reset();
    set_io(1, 1, 12'h005, 31'h12345678, 0);
    step();
    set_io(0, 0, '0, '0, 0);
    set_cpu(1, 0, 12'h005, '0);
    step();
    check_val("rd_gnt_same_cycle", 32'(obs_cg), 32'd1);
    set_cpu(0, 0, '0, '0);
    step();
    check_val("rd_rvalid_next", 32'(obs_crv), 32'd1);
    check_val("rd_data", 32'(obs_rdata), 32'h12345678);

    // Top address, all-ones data, IO write then CPU read.
    set_io(1, 1, 12'hFFF, 31'h7FFFFFFF, 0);
    step();
    set_io(0, 0, '0, '0, 0);
    set_cpu(1, 0, 12'hFFF, '0);
    step();
    set_cpu(0, 0, '0, '0);
    step();
    check_val("fff_rvalid", 32'(obs_crv), 32'd1);
    check_val("fff_data", 32'(obs_rdata), 32'h7FFFFFFF);

    // Both ports held continuously, no lock: 4 CPU then 1 IO, repeating.
    do_reset();
    set_cpu(1, 0, 12'h005, '0);
    set_io(1, 0, 12'hFFF, '0, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      check_val("starve_io", 32'(obs_ig), 32'(i % 5 == 4));
      check_val("starve_cpu", 32'(obs_cg), 32'(i % 5 != 4));
      if (last_cg) set_cpu(1, 0, 12'($urandom_range(0, 15)), '0);
      if (last_ig) set_io(1, 0, 12'($urandom_range(0, 15)), '0, 0);
    end

    // Locked IO burst against constant CPU demand: 8 IO, 1 CPU, rest of IO.
    do_reset();
    set_cpu(1, 0, 12'h003, '0);
    set_io(1, 1, 12'h010, 31'($urandom), 1);
    io_done = 0; first_run = 0; cpu_mid = 0; seen_io = 0; run_open = 1;
    for (int i = 0; i < 60 && io_done < 10; i++) begin
      step();
      if (obs_ig) begin
        seen_io = 1;
        io_done++;
        if (run_open) first_run++;
        if (io_done < 10) set_io(1, 1, 12'(16 + io_done), 31'($urandom), 1);
        else set_io(0, 0, '0, '0, 0);
      end
      if (obs_cg && seen_io) begin
        run_open = 0;
        if (io_done < 10) cpu_mid++;
      end
      if (last_cg) set_cpu(1, 0, 12'($urandom_range(0, 31)), '0);
    end
    check_val("burst_io_total", 32'(io_done), 32'd10);
    check_val("burst_first_run", 32'(first_run), 32'(MAX_BURST));
    check_val("burst_cpu_slots", 32'(cpu_mid), 32'd1);

    // Reset the cycle after a read grant suppresses the read's rvalid.
    do_reset();
    set_cpu(1, 0, 12'h005, '0);
    step();
    set_cpu(0, 0, '0, '0);
    reset = 1;
    step();
    check_val("reset_kills_rvalid", 32'(obs_crv), 32'd0);
    reset = 0;
    set_cpu(1, 0, 12'h001, '0);
    set_io(1, 0, 12'h002, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("wait_cleared", 32'(obs_ig), 32'(i == 4));
      if (last_cg) set_cpu(1, 0, 12'($urandom_range(0, 15)), '0);
      if (last_ig) set_io(1, 0, 12'($urandom_range(0, 15)), '0, 0);
    end

    // Alternating single-port reads: rvalid ping-pongs between the ports.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        set_cpu(1, 0, 12'(i), '0);
        set_io(0, 0, '0, '0, 0);
      end else begin
        set_cpu(0, 0, '0, '0);
        set_io(1, 0, 12'(i), '0, 0);
      end
      step();
      check_val("alt_cpu_rvalid", 32'(obs_crv), 32'(i % 2 == 1));
      check_val("alt_io_rvalid", 32'(obs_irv), 32'(i >= 2 && i % 2 == 0));
    end

    // Random traffic: requests held until granted, random lock, rare resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (!bus.cpu_req || last_cg)
        set_cpu($urandom_range(0, 3) != 0, 1'($urandom), 12'($urandom_range(0, 15)), 31'($urandom));
      if (!bus.io_req || last_ig)
        set_io($urandom_range(0, 2) != 0, 1'($urandom), 12'($urandom_range(0, 15)), 31'($urandom),
               1'($urandom));
      else
        bus.io_lock = 1'($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
      if (reset) begin last_cg = 0; last_ig = 0; end
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
